// File: rtl/vx_warp_ibuffer_if.sv
// Valid/ready instruction channel shared by the fetch response side and the decode side
// of vx_warp_ibuffer; the producer uses the master modport, the consumer the slave modport.
interface vx_warp_ibuffer_if #(
  parameter int NUM_WARPS   = 4,
  parameter int NUM_THREADS = 4,
  parameter int XLEN        = 32,
  parameter int UUID_BITS   = 44
);
  localparam int NW_BITS = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
  localparam int UW      = (UUID_BITS > 0) ? UUID_BITS : 1;

  logic                   valid;
  logic                   ready;
  logic [UW-1:0]          uuid;
  logic [NUM_THREADS-1:0] tmask;
  logic [NW_BITS-1:0]     wid;
  logic [XLEN-1:0]        PC;
  logic [31:0]            data;

  modport master (output valid, uuid, tmask, wid, PC, data, input ready);
  modport slave  (input valid, uuid, tmask, wid, PC, data, output ready);
endinterface

// File: rtl/vx_warp_ibuffer.sv
// Per-warp instruction FIFOs with round-robin issue to decode and per-warp pop pulses.
// Optional macro VX_IBUF_PERF_EN adds saturating stall/empty performance counters.
module vx_warp_ibuffer #(
  parameter int NUM_WARPS   = 4,
  parameter int NUM_THREADS = 4,
  parameter int XLEN        = 32,
  parameter int UUID_BITS   = 44,
  parameter int DEPTH       = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  vx_warp_ibuffer_if.slave     i_ifetch,
  vx_warp_ibuffer_if.master    o_ibuf,
  output logic [NUM_WARPS-1:0] ibuf_pop
`ifdef VX_IBUF_PERF_EN
  ,
  output logic [43:0]          perf_stall_cycles,
  output logic [43:0]          perf_empty_cycles
`endif
);
  localparam int NW_BITS = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
  localparam int UW      = (UUID_BITS > 0) ? UUID_BITS : 1;
  localparam int PW      = $clog2(DEPTH);
  localparam int CW      = $clog2(DEPTH + 1);
  localparam int EW      = UW + NUM_THREADS + XLEN + 32;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [1:0]           r_rst_sync;
  logic                 w_rst_n;
  logic [EW-1:0]        r_mem   [NUM_WARPS][DEPTH];
  logic [PW-1:0]        r_head  [NUM_WARPS];
  logic [PW-1:0]        r_tail  [NUM_WARPS];
  logic [CW-1:0]        r_count [NUM_WARPS];
  logic [NW_BITS-1:0]   r_rr_ptr;
  logic [NW_BITS-1:0]   r_lock_wid;
  logic                 r_lock;
  logic [NUM_WARPS-1:0] r_pop;

  logic                 w_wid_ok;
  logic                 w_enq_ready;
  logic                 w_enq;
  logic [NUM_WARPS-1:0] w_cand;
  logic                 w_rr_found;
  logic [NW_BITS-1:0]   w_rr_grant;
  logic [NW_BITS-1:0]   w_grant;
  logic [NW_BITS-1:0]   w_rr_next;
  logic                 w_valid;
  logic                 w_fire;
  logic [NUM_WARPS-1:0] w_enq_vec;
  logic [NUM_WARPS-1:0] w_deq_vec;
  logic [EW-1:0]        w_entry;

  // Reset synchronizer: assertion propagates immediately, release waits two clock edges.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end
  assign w_rst_n = r_rst_sync[1];

  // Enqueue acceptance, round-robin search, grant lock and output entry selection.
  always_comb begin
    w_wid_ok    = (int'(i_ifetch.wid) < NUM_WARPS);
    w_enq_ready = 1'b0;
    if (w_wid_ok) begin
      w_enq_ready = (r_count[i_ifetch.wid] != FULL_CNT);
    end else begin
      w_enq_ready = 1'b0;
    end
    w_enq = i_ifetch.valid && w_enq_ready;

    w_cand     = '0;
    w_rr_found = 1'b0;
    w_rr_grant = r_rr_ptr;
    for (int w = 0; w < NUM_WARPS; w++) begin
      w_cand[w] = (r_count[w] != CW'(0));
    end
    for (int i = 0; i < NUM_WARPS; i++) begin
      if (!w_rr_found && w_cand[(int'(r_rr_ptr) + i) % NUM_WARPS]) begin
        w_rr_found = 1'b1;
        w_rr_grant = NW_BITS'((int'(r_rr_ptr) + i) % NUM_WARPS);
      end else begin
        w_rr_found = w_rr_found;
      end
    end

    // A stalled grant stays put so decode sees stable fields until it accepts.
    if (r_lock) begin
      w_grant = r_lock_wid;
    end else begin
      w_grant = w_rr_grant;
    end
    w_valid   = |w_cand;
    w_fire    = w_valid && o_ibuf.ready;
    w_rr_next = NW_BITS'((int'(w_grant) + 1) % NUM_WARPS);
    w_entry   = r_mem[w_grant][r_head[w_grant]];

    w_enq_vec = '0;
    w_deq_vec = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      w_enq_vec[w] = w_enq && (int'(i_ifetch.wid) == w);
      w_deq_vec[w] = w_fire && (int'(w_grant) == w);
    end
  end

  assign i_ifetch.ready = w_enq_ready;
  assign o_ibuf.valid   = w_valid;
  assign o_ibuf.wid     = w_grant;
  assign o_ibuf.data    = w_entry[31:0];
  assign o_ibuf.PC      = w_entry[32 +: XLEN];
  assign o_ibuf.tmask   = w_entry[32 + XLEN +: NUM_THREADS];
  assign o_ibuf.uuid    = (UUID_BITS > 0) ? w_entry[32 + XLEN + NUM_THREADS +: UW] : {UW{1'b0}};
  assign ibuf_pop       = r_pop;

  // Entry storage; contents are only meaningful where count says so, so no reset.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_mem[i_ifetch.wid][r_tail[i_ifetch.wid]] <=
        {i_ifetch.uuid, i_ifetch.tmask, i_ifetch.PC, i_ifetch.data};
    end else begin
      r_mem <= r_mem;
    end
  end

  // Pointers, counts, arbitration state and the registered pop pulse.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        r_head[w]  <= PW'(0);
        r_tail[w]  <= PW'(0);
        r_count[w] <= CW'(0);
      end
      r_rr_ptr   <= NW_BITS'(0);
      r_lock_wid <= NW_BITS'(0);
      r_lock     <= 1'b0;
      r_pop      <= '0;
    end else begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        if (w_enq_vec[w]) r_tail[w] <= r_tail[w] + PW'(1);
        if (w_deq_vec[w]) r_head[w] <= r_head[w] + PW'(1);
        case ({w_enq_vec[w], w_deq_vec[w]})
          2'b10:   r_count[w] <= r_count[w] + CW'(1);
          2'b01:   r_count[w] <= r_count[w] - CW'(1);
          default: r_count[w] <= r_count[w];
        endcase
      end
      if (w_fire) begin
        r_rr_ptr <= w_rr_next;
        r_lock   <= 1'b0;
      end else if (w_valid) begin
        r_lock     <= 1'b1;
        r_lock_wid <= w_grant;
      end else begin
        r_lock <= 1'b0;
      end
      r_pop <= w_deq_vec;
    end
  end

`ifdef VX_IBUF_PERF_EN
  logic [43:0] r_perf_stall;
  logic [43:0] r_perf_empty;

  // Saturating counters of refused fetch requests and idle decode cycles.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_perf_stall <= 44'd0;
      r_perf_empty <= 44'd0;
    end else begin
      if (i_ifetch.valid && !w_enq_ready && (r_perf_stall != {44{1'b1}})) begin
        r_perf_stall <= r_perf_stall + 44'd1;
      end else begin
        r_perf_stall <= r_perf_stall;
      end
      if (!w_valid && (r_perf_empty != {44{1'b1}})) begin
        r_perf_empty <= r_perf_empty + 44'd1;
      end else begin
        r_perf_empty <= r_perf_empty;
      end
    end
  end
  assign perf_stall_cycles = r_perf_stall;
  assign perf_empty_cycles = r_perf_empty;
`endif

  vx_warp_ibuffer_chk #(
    .NUM_WARPS (NUM_WARPS),
    .NW_BITS   (NW_BITS)
  ) u_chk (
    .clk     (clk),
    .rst_n   (w_rst_n),
    .i_valid (i_ifetch.valid),
    .i_wid   (i_ifetch.wid)
  );
endmodule

// Simulation-only protocol checks on the fetch response channel.
module vx_warp_ibuffer_chk #(
  parameter int NUM_WARPS = 4,
  parameter int NW_BITS   = 2
) (
  input logic               clk,
  input logic               rst_n,
  input logic               i_valid,
  input logic [NW_BITS-1:0] i_wid
);
  a_wid_range: assert property (@(posedge clk) disable iff (!rst_n)
    i_valid |-> (int'(i_wid) < NUM_WARPS))
    else $error("vx_warp_ibuffer: ifetch_wid %0d out of range", i_wid);
endmodule

// File: tb/tb_vx_warp_ibuffer.sv
// Directed, table-driven bench for vx_warp_ibuffer (4 warps, depth 2).
module tb_vx_warp_ibuffer;
  logic       clk;
  logic       reset_n;
  logic [3:0] ibuf_pop;
  int         n_checks;
  int         n_fail;
`ifdef VX_IBUF_PERF_EN
  logic [43:0] perf_stall_cycles;
  logic [43:0] perf_empty_cycles;
`endif

  vx_warp_ibuffer_if #(.NUM_WARPS(4), .NUM_THREADS(4), .XLEN(32), .UUID_BITS(44)) ifetch_bus ();
  vx_warp_ibuffer_if #(.NUM_WARPS(4), .NUM_THREADS(4), .XLEN(32), .UUID_BITS(44)) ibuf_bus ();

  vx_warp_ibuffer #(
    .NUM_WARPS(4), .NUM_THREADS(4), .XLEN(32), .UUID_BITS(44), .DEPTH(2)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_ifetch (ifetch_bus),
    .o_ibuf   (ibuf_bus),
    .ibuf_pop (ibuf_pop)
`ifdef VX_IBUF_PERF_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_empty_cycles (perf_empty_cycles)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic        iv;
    logic [1:0]  wid;
    logic [31:0] pc;
    logic        ir;
    logic        e_fr;
    logic        e_v;
    logic [1:0]  e_wid;
    logic [31:0] e_pc;
    logic [3:0]  e_pop;
  } vec_t;

  vec_t tv [24];

  function automatic vec_t mk(input logic iv, input logic [1:0] wid, input logic [31:0] pc,
                              input logic ir, input logic e_fr, input logic e_v,
                              input logic [1:0] e_wid, input logic [31:0] e_pc,
                              input logic [3:0] e_pop);
    vec_t v;
    v.iv = iv; v.wid = wid; v.pc = pc; v.ir = ir; v.e_fr = e_fr; v.e_v = e_v;
    v.e_wid = e_wid; v.e_pc = e_pc; v.e_pop = e_pop;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Payload fields are derived from PC and warp so every output field is predictable.
  task automatic drive(input logic iv, input logic [1:0] wid, input logic [31:0] pc, input logic ir);
    ifetch_bus.valid = iv;
    ifetch_bus.wid   = wid;
    ifetch_bus.PC    = pc;
    ifetch_bus.data  = pc ^ 32'h8000_0013;
    ifetch_bus.uuid  = {12'hABC, pc};
    ifetch_bus.tmask = 4'b0001 << wid;
    ibuf_bus.ready   = ir;
  endtask

  task automatic chk_out(input string tag, input logic [1:0] e_wid, input logic [31:0] e_pc);
    chk({tag, ".wid"},   64'(ibuf_bus.wid),   64'(e_wid));
    chk({tag, ".pc"},    64'(ibuf_bus.PC),    64'(e_pc));
    chk({tag, ".data"},  64'(ibuf_bus.data),  64'(e_pc ^ 32'h8000_0013));
    chk({tag, ".uuid"},  64'(ibuf_bus.uuid),  64'({12'hABC, e_pc}));
    chk({tag, ".tmask"}, 64'(ibuf_bus.tmask), 64'(4'b0001 << e_wid));
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] sq[$];
    int          sent;
    int          rcvd;
    int          full_pop_seen;
    logic        prev_fire;
    logic        fr_exp;
    logic        iv_s;
    logic        ir_s;

    n_checks = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    drive(1'b0, 2'd0, 32'd0, 1'b0);

    tv[0]  = mk(0, 2'd0, 32'h0,        1, 1, 0, 2'd0, 32'h0,        4'b0000);
    tv[1]  = mk(1, 2'd1, 32'h8000_0000, 1, 1, 0, 2'd0, 32'h0,        4'b0000);
    tv[2]  = mk(0, 2'd0, 32'h0,        1, 1, 1, 2'd1, 32'h8000_0000, 4'b0000);
    tv[3]  = mk(0, 2'd0, 32'h0,        1, 1, 0, 2'd0, 32'h0,        4'b0010);
    tv[4]  = mk(0, 2'd0, 32'h0,        1, 1, 0, 2'd0, 32'h0,        4'b0000);
    tv[5]  = mk(1, 2'd2, 32'h0000_00A0, 0, 1, 0, 2'd0, 32'h0,        4'b0000);
    tv[6]  = mk(1, 2'd2, 32'h0000_00A4, 0, 1, 1, 2'd2, 32'h0000_00A0, 4'b0000);
    tv[7]  = mk(1, 2'd2, 32'h0000_00A8, 0, 0, 1, 2'd2, 32'h0000_00A0, 4'b0000);
    tv[8]  = mk(1, 2'd0, 32'h0000_00B0, 0, 1, 1, 2'd2, 32'h0000_00A0, 4'b0000);
    tv[9]  = mk(0, 2'd0, 32'h0,        1, 1, 1, 2'd2, 32'h0000_00A0, 4'b0000);
    tv[10] = mk(0, 2'd0, 32'h0,        1, 1, 1, 2'd0, 32'h0000_00B0, 4'b0100);
    tv[11] = mk(0, 2'd0, 32'h0,        1, 1, 1, 2'd2, 32'h0000_00A4, 4'b0001);
    tv[12] = mk(0, 2'd0, 32'h0,        1, 1, 0, 2'd0, 32'h0,        4'b0100);
    tv[13] = mk(0, 2'd0, 32'h0,        1, 1, 0, 2'd0, 32'h0,        4'b0000);
    tv[14] = mk(1, 2'd0, 32'h0000_00C0, 0, 1, 0, 2'd0, 32'h0,        4'b0000);
    tv[15] = mk(1, 2'd1, 32'h0000_00C4, 0, 1, 1, 2'd0, 32'h0000_00C0, 4'b0000);
    tv[16] = mk(1, 2'd2, 32'h0000_00C8, 0, 1, 1, 2'd0, 32'h0000_00C0, 4'b0000);
    tv[17] = mk(1, 2'd3, 32'h0000_00CC, 0, 1, 1, 2'd0, 32'h0000_00C0, 4'b0000);
    tv[18] = mk(0, 2'd0, 32'h0,        1, 1, 1, 2'd0, 32'h0000_00C0, 4'b0000);
    tv[19] = mk(0, 2'd0, 32'h0,        1, 1, 1, 2'd1, 32'h0000_00C4, 4'b0001);
    tv[20] = mk(0, 2'd0, 32'h0,        1, 1, 1, 2'd2, 32'h0000_00C8, 4'b0010);
    tv[21] = mk(0, 2'd0, 32'h0,        1, 1, 1, 2'd3, 32'h0000_00CC, 4'b0100);
    tv[22] = mk(0, 2'd0, 32'h0,        1, 1, 0, 2'd0, 32'h0,        4'b1000);
    tv[23] = mk(0, 2'd0, 32'h0,        1, 1, 0, 2'd0, 32'h0,        4'b0000);

    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (3) next_cycle();

    for (int r = 0; r < 24; r++) begin
      drive(tv[r].iv, tv[r].wid, tv[r].pc, tv[r].ir);
      #1;
      chk($sformatf("row%0d.ifetch_ready", r), 64'(ifetch_bus.ready), 64'(tv[r].e_fr));
      chk($sformatf("row%0d.ibuf_valid", r),   64'(ibuf_bus.valid),   64'(tv[r].e_v));
      chk($sformatf("row%0d.ibuf_pop", r),     64'(ibuf_pop),         64'(tv[r].e_pop));
      if (tv[r].e_v) chk_out($sformatf("row%0d", r), tv[r].e_wid, tv[r].e_pc);
      next_cycle();
    end

    // Stall hold: warp 3 locked while warp 0 (ahead in rr order) arrives.
    drive(1'b1, 2'd3, 32'h0000_00D0, 1'b0);
    #1 chk("stall.pre_valid", 64'(ibuf_bus.valid), 64'd0);
    next_cycle();
    for (int k = 0; k < 5; k++) begin
      drive(k == 0, 2'd0, 32'h0000_00E0, 1'b0);
      #1;
      chk($sformatf("stall%0d.valid", k), 64'(ibuf_bus.valid), 64'd1);
      chk_out($sformatf("stall%0d", k), 2'd3, 32'h0000_00D0);
      next_cycle();
    end
    drive(1'b0, 2'd0, 32'h0, 1'b1);
    #1 chk_out("stall.rel0", 2'd3, 32'h0000_00D0);
    next_cycle();
    #1;
    chk("stall.rel1.valid", 64'(ibuf_bus.valid), 64'd1);
    chk_out("stall.rel1", 2'd0, 32'h0000_00E0);
    chk("stall.rel1.pop", 64'(ibuf_pop), 64'(4'b1000));
    next_cycle();
    #1;
    chk("stall.rel2.valid", 64'(ibuf_bus.valid), 64'd0);
    chk("stall.rel2.pop", 64'(ibuf_pop), 64'(4'b0001));
    next_cycle();

    // Ten entries streamed through warp 1 against a queue model; decode accepts every third cycle.
    sent = 0; rcvd = 0; full_pop_seen = 0; prev_fire = 1'b0;
    for (int k = 0; k < 80 && rcvd < 10; k++) begin
      iv_s = (sent < 10);
      ir_s = ((k % 3) == 2);
      drive(iv_s, 2'd1, 32'h9000_0000 + 32'(sent * 4), ir_s);
      #1;
      fr_exp = (sq.size() != 2);
      chk($sformatf("strm%0d.ifetch_ready", k), 64'(ifetch_bus.ready), 64'(fr_exp));
      chk($sformatf("strm%0d.valid", k), 64'(ibuf_bus.valid), 64'(sq.size() != 0));
      chk($sformatf("strm%0d.pop", k), 64'(ibuf_pop), prev_fire ? 64'(4'b0010) : 64'd0);
      if (sq.size() != 0) chk_out($sformatf("strm%0d", k), 2'd1, sq[0]);
      if (!fr_exp && ir_s && iv_s && ibuf_bus.valid && !ifetch_bus.ready) full_pop_seen++;
      prev_fire = ir_s && (sq.size() != 0);
      if (iv_s && fr_exp) begin
        sq.push_back(32'h9000_0000 + 32'(sent * 4));
        sent++;
      end
      if (prev_fire) begin
        void'(sq.pop_front());
        rcvd++;
      end
      next_cycle();
    end
    chk("strm.received", 64'(rcvd), 64'd10);
    chk("strm.full_and_pop_cycles_seen", 64'(full_pop_seen != 0), 64'd1);
    drive(1'b0, 2'd0, 32'h0, 1'b0);
    next_cycle();

    // Reset mid-stream with a pop pulse pending and three entries left.
    drive(1'b1, 2'd0, 32'h0000_0100, 1'b0); next_cycle();
    drive(1'b1, 2'd2, 32'h0000_0104, 1'b0); next_cycle();
    drive(1'b1, 2'd2, 32'h0000_0108, 1'b0); next_cycle();
    drive(1'b1, 2'd1, 32'h0000_010C, 1'b0); next_cycle();
    drive(1'b0, 2'd2, 32'h0, 1'b1);
    next_cycle();
    drive(1'b0, 2'd2, 32'h0, 1'b0);
    #1;
    chk("rst.pre.valid", 64'(ibuf_bus.valid), 64'd1);
    chk("rst.pre.pop_onehot", 64'($countones(ibuf_pop)), 64'd1);
    chk("rst.pre.ifetch_ready_w2", 64'(ifetch_bus.ready), 64'd0);
    #1 reset_n = 1'b0;
    #1;
    chk("rst.async.valid", 64'(ibuf_bus.valid), 64'd0);
    chk("rst.async.pop", 64'(ibuf_pop), 64'd0);
    chk("rst.async.ifetch_ready", 64'(ifetch_bus.ready), 64'd1);
`ifdef VX_IBUF_PERF_EN
    chk("rst.perf_stall", 64'(perf_stall_cycles), 64'd0);
    chk("rst.perf_empty", 64'(perf_empty_cycles), 64'd0);
`endif
    next_cycle();
    next_cycle();
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("rst.post%0d.valid", k), 64'(ibuf_bus.valid), 64'd0);
      chk($sformatf("rst.post%0d.pop", k), 64'(ibuf_pop), 64'd0);
      chk($sformatf("rst.post%0d.ifetch_ready", k), 64'(ifetch_bus.ready), 64'd1);
      next_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/vx_warp_ibuffer.md
Name: vx_warp_ibuffer

Overview:
Per-warp instruction buffer sitting directly downstream of the fetch response channel. It accepts fetched instructions tagged with a warp ID and queues them in one small FIFO per warp. It issues them to decode through a single round-robin arbitrated valid/ready port. It returns a one-cycle ibuf_pop pulse per warp so fetch can track per-warp buffer credits.

Parameters:
NUM_WARPS, 4, number of warps; NW_BITS = max(1, clog2(NUM_WARPS))
NUM_THREADS, 4, thread mask width
XLEN, 32, PC width
UUID_BITS, 44, instruction UUID width; 0 maps to a 1-bit tied-zero field
DEPTH, 2, entries per warp FIFO; legal values are 2 to 8, power of two

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
ifetch_valid  input  1  fetch response valid
ifetch_uuid  input  max(1,UUID_BITS)  instruction UUID
ifetch_tmask  input  NUM_THREADS  thread mask
ifetch_wid  input  NW_BITS  warp ID
ifetch_PC  input  XLEN  instruction PC
ifetch_data  input  32  instruction word
ifetch_ready  output  1  buffer can accept for ifetch_wid
ibuf_pop  output  NUM_WARPS  one-cycle pulse per dequeued warp entry
ibuf_valid  output  1  decode-side valid
ibuf_uuid  output  max(1,UUID_BITS)  selected UUID
ibuf_tmask  output  NUM_THREADS  selected tmask
ibuf_wid  output  NW_BITS  selected warp
ibuf_PC  output  XLEN  selected PC
ibuf_data  output  32  selected instruction
ibuf_ready  input  1  decode accepts

Behaviour:
- Clock and reset: single clock domain `clk`. Reset is asynchronous and active-low on `reset_n`, asserted asynchronously and released synchronously.
- Reset clears all counts, pointers, grant lock and ibuf_pop, and sets the round-robin pointer to 0. Afterwards ibuf_valid=0, ibuf_pop=0, ifetch_ready=1. Data outputs are don't-care while ibuf_valid=0.
- Per-warp state: head/tail pointers of clog2(DEPTH) bits with natural wrap, and a count of 0..DEPTH.
- ifetch_ready is combinational: (count[ifetch_wid] != DEPTH). It uses the count before any same-cycle dequeue, so a full warp cannot enqueue in the cycle it pops.
- Enqueue fires on ifetch_valid && ifetch_ready: write to tail, tail+1, count+1.
- Latency: an enqueued entry is visible at the output no earlier than the next cycle; there is no bypass.
- Arbitration: the candidate set is warps with count != 0. The grant goes to the first candidate at or after rr_ptr, in modulo NUM_WARPS order.
- The output mux presents the granted warp's head entry combinationally; ibuf_valid = any candidate.
- Dequeue fires on ibuf_valid && ibuf_ready: head+1, count-1, rr_ptr <= grant+1 (mod NUM_WARPS).
- Stall hold: if ibuf_valid && !ibuf_ready, the grant is locked to the current warp until it fires, so output fields stay stable. New arrivals on other warps must not change the grant.
- Simultaneous enqueue and dequeue on the same warp: count is unchanged; head and tail both advance.
- ibuf_pop[w] is registered and equals 1 exactly one cycle after a dequeue from warp w; at most one bit is set per cycle.
- Reset mid-operation discards all entries without generating pops.
- Protocol assertion (simulation only): ifetch_valid with ifetch_wid >= NUM_WARPS is an error.

Optional Feature:
VX_IBUF_PERF_EN
- Defined: adds output perf_stall_cycles (44 bits), which increments every cycle ifetch_valid && !ifetch_ready. Adds output perf_empty_cycles (44 bits), which increments every cycle ibuf_valid=0. Both clear on reset and saturate at all-ones.
- Undefined: neither port nor counter exists, and functional behaviour is identical.

Test Plan:
- Reset, then enqueue wid=1 PC=0x80000000 data=0x00000013 -> ibuf_valid rises the next cycle with wid=1 and matching fields. With ibuf_ready=1, the pop fires; ibuf_pop=4'b0010 for one cycle on the following cycle.
- Fill wid=2 with DEPTH=2 entries, ibuf_ready=0 -> third request on wid=2 sees ifetch_ready=0, while a concurrent request on wid=0 sees ifetch_ready=1.
- One entry in each of warps 0-3, ibuf_ready=1 -> issue order 0,1,2,3, then ibuf_valid=0; ibuf_pop shows 0001,0010,0100,1000 on consecutive cycles.
- Warp 3 granted with ibuf_ready=0 for 5 cycles while warp 0 is enqueued -> outputs hold warp 3 fields unchanged. When ready rises, warp 3 issues first, then warp 0.
- Warp 1 full with ibuf_ready=1 dequeuing warp 1 while ifetch_valid on wid=1 -> ifetch_ready=0 that cycle and the entry is accepted the next cycle. Count never exceeds 2, and FIFO order is preserved across pointer wrap over 10 entries.
- Assert reset_n low mid-stream with 3 entries buffered -> outputs clear immediately without waiting for a clock edge, no ibuf_pop pulses, and ifetch_ready=1 after release. With VX_IBUF_PERF_EN, both counters read 0.
